pipe_stage_reg: RTL and testbench



---
 rtl/pipe_pkg.sv | 34 +++
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 124 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for datapath pipeline stage registers:
// ID/EX control layout, bubble encoding and skid-buffer states.
package pipe_pkg;

  localparam int NPC_OP_W  = 2;
  localparam int RF_WSEL_W = 2;
  localparam int RF_WE_W   = 1;
  localparam int SEXT_OP_W = 3;
  localparam int ALU_OP_W  = 4;
  localparam int B_SEL_W   = 1;
  localparam int BR_OP_W   = 3;
  localparam int DRAM_WE_W = 1;

  localparam int DRAM_WE_OFF = 0;
  localparam int BR_OP_OFF   = DRAM_WE_OFF + DRAM_WE_W;
  localparam int B_SEL_OFF   = BR_OP_OFF + BR_OP_W;
  localparam int ALU_OP_OFF  = B_SEL_OFF + B_SEL_W;
  localparam int SEXT_OP_OFF = ALU_OP_OFF + ALU_OP_W;
  localparam int RF_WE_OFF   = SEXT_OP_OFF + SEXT_OP_W;
  localparam int RF_WSEL_OFF = RF_WE_OFF + RF_WE_W;
  localparam int NPC_OP_OFF  = RF_WSEL_OFF + RF_WSEL_W;

  localparam int ID_EX_CTRL_W = NPC_OP_OFF + NPC_OP_W;

  // All-zero control keeps rf_we and dram_we low, so a bubble is harmless.
  localparam logic [ID_EX_CTRL_W-1:0] CTRL_NOP_ENC = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat interface between two pipeline stages,
// carrying the control and data bundles on both sides of a stage.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = 128
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear,
// used for performance-debug event counts.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with flush, optional skid
// buffer, occupancy and saturating downstream-stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = ID_EX_CTRL_W,
  parameter int                DATA_W      = 128,
  parameter logic [CTRL_W-1:0] CTRL_NOP    = '0,
  parameter int                SKID        = 1,
  parameter int                STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_reg_if.slave        bus,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  skid_state_e       state;
  skid_state_e       nstate;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              rdy_q;
  logic              vld;
  logic              in_rdy;
  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic              load_skid;
  logic              shift;

  assign vld      = (state != EMPTY);
  assign in_fire  = bus.in_valid & in_rdy;
  assign out_fire = vld & bus.out_ready;

  // Without a skid slot the stage can only take a beat as one leaves.
  assign in_rdy = (SKID != 0) ? rdy_q
                : (!rst & (bus.out_ready | !vld));

  always_comb begin
    nstate    = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      nstate = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            nstate    = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          unique case ({in_fire, out_fire})
            2'b11: load_main = 1'b1;
            2'b10: begin
              nstate    = TWO;
              load_skid = 1'b1;
            end
            2'b01: nstate = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (out_fire) begin
            nstate = ONE;
            shift  = 1'b1;
          end
        end
        default: nstate = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      rdy_q       <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state <= nstate;
      rdy_q <= (nstate != TWO);
      if (load_main) begin
        ctrl_q <= bus.in_ctrl;
        data_q <= bus.in_data;
      end else if (shift) begin
        ctrl_q <= skid_ctrl_q;
        data_q <= skid_data_q;
      end
      if (flush) begin
        skid_ctrl_q <= '0;
        skid_data_q <= '0;
      end else if (load_skid) begin
        skid_ctrl_q <= bus.in_ctrl;
        skid_data_q <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld;
  assign bus.out_ctrl  = vld ? ctrl_q : CTRL_NOP;
  assign bus.out_data  = data_q;
  assign occupancy     = state;

  sat_counter #(
    .W (STALL_CNT_W)
  ) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (vld & !bus.out_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, single-register and
// narrow-counter variants driven side by side.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic f1  = 1'b0;
  logic f0  = 1'b0;
  logic f3  = 1'b0;
  logic [1:0]  o1, o0, o3;
  logic [15:0] s1, s0;
  logic [2:0]  s3;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg_if #(.CTRL_W(17), .DATA_W(128)) b1 ();
  pipe_stage_reg_if #(.CTRL_W(17), .DATA_W(128)) b0 ();
  pipe_stage_reg_if #(.CTRL_W(17), .DATA_W(128)) b3 ();

  pipe_stage_reg #(.SKID(1), .STALL_CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .flush(f1), .bus(b1),
    .occupancy(o1), .stall_cnt(s1));
  pipe_stage_reg #(.SKID(0), .STALL_CNT_W(16)) d0 (
    .clk(clk), .rst(rst), .flush(f0), .bus(b0),
    .occupancy(o0), .stall_cnt(s0));
  pipe_stage_reg #(.SKID(1), .STALL_CNT_W(3)) d3 (
    .clk(clk), .rst(rst), .flush(f3), .bus(b3),
    .occupancy(o3), .stall_cnt(s3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b1.in_valid = 0; b1.in_ctrl = '0; b1.in_data = '0; b1.out_ready = 0;
    b0.in_valid = 0; b0.in_ctrl = '0; b0.in_data = '0; b0.out_ready = 0;
    b3.in_valid = 0; b3.in_ctrl = '0; b3.in_data = '0; b3.out_ready = 0;
    rst = 1;
    tick();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_ctrl !== 17'h0) begin n_err++; $display("FAIL rst_ctrl got %h want 0", b1.out_ctrl); end
    n_cmp++; if (b1.out_data !== 128'h0) begin n_err++; $display("FAIL rst_data got %h want 0", b1.out_data); end
    n_cmp++; if (o1 !== 2'd0) begin n_err++; $display("FAIL rst_occ got %0d want 0", o1); end
    n_cmp++; if (s1 !== 16'd0) begin n_err++; $display("FAIL rst_stall got %0d want 0", s1); end
    n_cmp++; if (b1.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_rdy1 got %b want 0", b1.in_ready); end
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_rdy0 got %b want 0", b0.in_ready); end
    #3 rst = 0;
    tick();
    n_cmp++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_rdy got %b want 1", b1.in_ready); end
  endtask

  task automatic test_single();
    b1.in_valid = 1; b1.in_ctrl = 17'h1A5A5; b1.in_data = 128'h4; b1.out_ready = 1;
    tick();
    b1.in_valid = 0;
    n_cmp++; if (b1.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", b1.out_valid); end
    n_cmp++; if (b1.out_ctrl !== 17'h1A5A5) begin n_err++; $display("FAIL single_ctrl got %h want 1a5a5", b1.out_ctrl); end
    n_cmp++; if (b1.out_data !== 128'h4) begin n_err++; $display("FAIL single_data got %h want 4", b1.out_data); end
    n_cmp++; if (o1 !== 2'd1) begin n_err++; $display("FAIL single_occ got %0d want 1", o1); end
    tick();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_ctrl !== 17'h0) begin n_err++; $display("FAIL drain_nop got %h want 0", b1.out_ctrl); end
    n_cmp++; if (b1.out_data !== 128'h4) begin n_err++; $display("FAIL drain_hold got %h want 4", b1.out_data); end
  endtask

  task automatic test_stall();
    b1.in_valid = 1; b1.in_ctrl = 17'h00077; b1.out_ready = 0;
    b3.in_valid = 1; b3.in_ctrl = 17'h00033; b3.out_ready = 0;
    tick();
    b1.in_valid = 0; b3.in_valid = 0;
    n_cmp++; if (s1 !== 16'd0) begin n_err++; $display("FAIL stall_start got %0d want 0", s1); end
    repeat (5) tick();
    n_cmp++; if (s1 !== 16'd5) begin n_err++; $display("FAIL stall5 got %0d want 5", s1); end
    n_cmp++; if (s3 !== 3'd5) begin n_err++; $display("FAIL stall3_5 got %0d want 5", s3); end
    b1.out_ready = 1;
    tick();
    b1.out_ready = 0;
    repeat (4) tick();
    n_cmp++; if (s1 !== 16'd5) begin n_err++; $display("FAIL stall_hold got %0d want 5", s1); end
    n_cmp++; if (s3 !== 3'd7) begin n_err++; $display("FAIL stall_sat got %0d want 7", s3); end
    b3.out_ready = 1;
    tick();
    b3.out_ready = 0;
  endtask

  task automatic test_back_to_back();
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_ctrl = 17'h0000A; b1.in_data = 128'hA;
    tick();
    n_cmp++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdyA got %b want 1", b1.in_ready); end
    b1.in_ctrl = 17'h0000B; b1.in_data = 128'hB;
    tick();
    b1.in_ctrl = 17'h0000C; b1.in_data = 128'hC;
    tick();
    n_cmp++; if (o1 !== 2'd2) begin n_err++; $display("FAIL b2b_occ got %0d want 2", o1); end
    n_cmp++; if (b1.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_rdy got %b want 0", b1.in_ready); end
    n_cmp++; if (b1.out_ctrl !== 17'h0000A) begin n_err++; $display("FAIL b2b_A got %h want a", b1.out_ctrl); end
    b1.out_ready = 1;
    tick();
    n_cmp++; if (b1.out_ctrl !== 17'h0000B) begin n_err++; $display("FAIL b2b_B got %h want b", b1.out_ctrl); end
    n_cmp++; if (o1 !== 2'd1) begin n_err++; $display("FAIL b2b_occB got %0d want 1", o1); end
    tick();
    b1.in_valid = 0;
    n_cmp++; if (b1.out_ctrl !== 17'h0000C) begin n_err++; $display("FAIL b2b_C got %h want c", b1.out_ctrl); end
    n_cmp++; if (b1.out_data !== 128'hC) begin n_err++; $display("FAIL b2b_Cdata got %h want c", b1.out_data); end
    tick();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", b1.out_valid); end
  endtask

  task automatic test_flush();
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_ctrl = 17'h0000D; b1.in_data = 128'hD;
    tick();
    b1.in_ctrl = 17'h0000E; b1.in_data = 128'hE;
    tick();
    f1 = 1; b1.in_ctrl = 17'h0000F; b1.in_data = 128'hF;
    tick();
    f1 = 0; b1.in_valid = 0;
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_ctrl !== 17'h0) begin n_err++; $display("FAIL flush_nop got %h want 0", b1.out_ctrl); end
    n_cmp++; if (o1 !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d want 0", o1); end
    n_cmp++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_rdy got %b want 1", b1.in_ready); end
    b1.in_valid = 1; b1.in_ctrl = 17'h00011;
    tick();
    f1 = 1; b1.in_ctrl = 17'h00012;
    tick();
    f1 = 0; b1.in_valid = 0; b1.out_ready = 1;
    tick();
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got %b want 0", b1.out_valid); end
    n_cmp++; if (o1 !== 2'd0) begin n_err++; $display("FAIL flush_drop_occ got %0d want 0", o1); end
  endtask

  task automatic test_reset_mid();
    b1.out_ready = 0;
    b1.in_valid = 1; b1.in_ctrl = 17'h00021; b1.in_data = 128'h21;
    tick();
    b1.in_ctrl = 17'h00022; b1.in_data = 128'h22;
    tick();
    b1.in_valid = 0;
    n_cmp++; if (o1 !== 2'd2) begin n_err++; $display("FAIL mid_full got %0d want 2", o1); end
    rst = 1;
    #1;
    n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", b1.out_valid); end
    n_cmp++; if (b1.out_data !== 128'h0) begin n_err++; $display("FAIL mid_data got %h want 0", b1.out_data); end
    n_cmp++; if (o1 !== 2'd0) begin n_err++; $display("FAIL mid_occ got %0d want 0", o1); end
    n_cmp++; if (b1.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rdy got %b want 0", b1.in_ready); end
    n_cmp++; if (s1 !== 16'd0) begin n_err++; $display("FAIL mid_stall got %0d want 0", s1); end
    #1 rst = 0;
    tick();
    n_cmp++; if (b1.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rdy_after got %b want 1", b1.in_ready); end
  endtask

  task automatic test_noskid();
    b0.out_ready = 1; b0.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b0.in_ctrl = 17'h00100 + 17'(i); b0.in_data = 128'(i);
      tick();
      n_cmp++; if (b0.out_ctrl !== 17'h00100 + 17'(i)) begin n_err++; $display("FAIL ns_beat%0d got %h want %h", i, b0.out_ctrl, 17'h00100 + 17'(i)); end
      n_cmp++; if (b0.in_ready !== 1'b1) begin n_err++; $display("FAIL ns_rdy%0d got %b want 1", i, b0.in_ready); end
    end
    b0.in_ctrl = 17'h00200; b0.out_ready = 0;
    #1;
    n_cmp++; if (b0.in_ready !== 1'b0) begin n_err++; $display("FAIL ns_rdy_drop got %b want 0", b0.in_ready); end
    tick();
    n_cmp++; if (b0.out_ctrl !== 17'h00103) begin n_err++; $display("FAIL ns_hold got %h want 103", b0.out_ctrl); end
    n_cmp++; if (o0 !== 2'd1) begin n_err++; $display("FAIL ns_occ got %0d want 1", o0); end
    b0.in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_noskid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
